m_serial_add_ctrl: RTL and testbench
====================================

M_SERIAL_ADD_CTRL -- requirements
Module: m_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 w_clk  input  1  single clock; all state updates on rising edge.
REQ-003 w_rst  input  1  reset; synchronous, active-high.
REQ-004 w_in_valid  input  1  operand request valid.
REQ-005 w_in_ready  output  1  controller can accept an operand request.
REQ-006 w_a  input  WIDTH  operand A.
REQ-007 w_b  input  WIDTH  operand B.
REQ-008 w_cin  input  1  carry-in; used in add mode only.
REQ-009 w_op  input  1  0 = add (A+B+cin), 1 = subtract (A+~B+1).
REQ-010 w_out_valid  output  1  result valid.
REQ-011 w_out_ready  input  1  consumer accepts result.
REQ-012 w_s  output  WIDTH  sum / difference.
REQ-013 w_cout  output  1  final carry out; in subtract mode 1 = no borrow.

Function
REQ-014 Three states SHALL exist: IDLE, RUN, DONE.
REQ-015 In IDLE, w_in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-016 On w_in_valid & w_in_ready, the controller SHALL latch A, B (inverted if w_op=1), carry register = (w_op ? 1 : w_cin), bit counter = 0, and go to RUN.
REQ-017 In RUN, each cycle the LSBs of the A and B shift registers plus the carry register SHALL drive one 1-bit full adder. The sum bit SHALL shift into the result register from the MSB side. The carry register SHALL take the adder's carry out. A and B SHALL shift right by 1. The counter SHALL increment.
REQ-018 When the counter reaches WIDTH-1 in RUN, the state SHALL become DONE on that edge, after exactly WIDTH RUN cycles.
REQ-019 In DONE, w_out_valid SHALL be 1, and w_s and w_cout SHALL hold stable until w_out_valid & w_out_ready.
REQ-020 On w_out_valid & w_out_ready, the state SHALL return to IDLE. A new request SHALL NOT be accepted in that same cycle.
REQ-021 Latency SHALL be WIDTH+1 cycles from the accept edge to the first cycle of w_out_valid=1.
REQ-022 w_in_valid while w_in_ready=0 SHALL be ignored. Operand inputs SHALL be sampled only at accept.
REQ-023 w_out_ready while w_out_valid=0 SHALL have no effect.
REQ-024 For WIDTH=1, RUN SHALL last one cycle.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH in w_s, with the carry/borrow indication only in w_cout. There is no overflow flag.
REQ-026 w_s and w_cout SHALL retain their last result values in IDLE and RUN.

Reset
REQ-027 While w_rst=1 at a clock edge: state = IDLE, counter = 0, carry = 0, shift registers = 0, w_s = 0, w_cout = 0, w_out_valid = 0.
REQ-028 Reset during RUN or DONE SHALL abort the operation with no result delivered. w_in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-030 Exactly one instance of the existing m_FA 1-bit full adder SHALL perform all arithmetic. The controller SHALL contain no other adder.
REQ-031 The counter width SHALL be clog2(WIDTH)+1 bits.

Verification (WIDTH=8)
REQ-032 Add: A=8'h5A, B=8'h3C, cin=0, op=0, out_ready=1. Required: w_out_valid rises 9 cycles after accept, w_s=8'h96, w_cout=0.
REQ-033 Carry wrap: A=8'hFF, B=8'h00, cin=1, op=0. Required: w_s=8'h00, w_cout=1. Also A=8'hFF, B=8'hFF, cin=1. Required: w_s=8'hFF, w_cout=1.
REQ-034 Subtract: A=8'h10, B=8'h01, op=1. Required: w_s=8'h0F, w_cout=1. Also A=8'h01, B=8'h02, op=1. Required: w_s=8'hFF, w_cout=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE, and toggle w_a/w_in_valid meanwhile. Required: w_s/w_cout stay stable, w_in_ready=0, no second accept. Release out_ready. Required: IDLE next cycle.
REQ-036 Reset mid-RUN: assert w_rst at RUN cycle 4. Required: next cycle w_out_valid=0, w_s=0, w_in_ready=1. A following request computes correctly.
REQ-037 Back-to-back: keep in_valid=1 with a new operand each accept, out_ready=1. Required: one accept every WIDTH+2 cycles, all results correct against a reference model.

Source files
------------

// File: rtl/m_serial_add_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// m_serial_add_ctrl_pkg
// Shared definitions for the bit-serial add/subtract controller:
//   - DEFAULT_WIDTH : default operand width
//   - state_t       : controller state encoding (IDLE/RUN/DONE)
// ----------------------------------------------------------------------------
package m_serial_add_ctrl_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : m_serial_add_ctrl_pkg

// File: rtl/m_serial_add_ctrl_fa.sv
// ----------------------------------------------------------------------------
// m_FA
// 1-bit full adder. This is the only arithmetic element of the serial
// add/subtract controller.
// Ports:
//   i_a, i_b  input  operand bits
//   i_cin     input  carry in
//   o_s       output sum bit
//   o_cout    output carry out
// ----------------------------------------------------------------------------
module m_FA (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : m_FA

// File: rtl/m_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// m_serial_add_ctrl
// Bit-serial adder/subtractor with valid/ready handshakes on both sides.
// An accepted request is processed LSB first, one bit per cycle, through a
// single full adder; the result is presented in DONE until consumed.
// Subtraction is A + ~B + 1 (B inverted at accept, carry seeded with 1).
// Ports:
//   w_clk        input   clock, rising edge
//   w_rst        input   synchronous active-high reset
//   w_in_valid   input   operand request valid
//   w_in_ready   output  controller idle, can accept a request
//   w_a, w_b     input   operands (WIDTH bits), sampled only at accept
//   w_cin        input   carry in (add mode only)
//   w_op         input   0 = add, 1 = subtract
//   w_out_valid  output  result valid
//   w_out_ready  input   consumer accepts result
//   w_s          output  sum / difference (modulo 2^WIDTH)
//   w_cout       output  final carry out (subtract: 1 = no borrow)
// ----------------------------------------------------------------------------
module m_serial_add_ctrl
   import m_serial_add_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic             w_in_valid,
   output logic             w_in_ready,
   input  logic [WIDTH-1:0] w_a,
   input  logic [WIDTH-1:0] w_b,
   input  logic             w_cin,
   input  logic             w_op,
   output logic             w_out_valid,
   input  logic             w_out_ready,
   output logic [WIDTH-1:0] w_s,
   output logic             w_cout
);

   localparam int unsigned      CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;         // operand A shift register
   logic [WIDTH-1:0]   r_b;         // operand B (pre-inverted for subtract)
   logic [WIDTH-1:0]   r_acc;       // partial result, filled from the MSB side
   logic [WIDTH-1:0]   r_s;         // published result, held outside DONE
   logic               r_carry;
   logic               r_cout;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_in_ready;
   logic               r_out_valid;

   logic               w_fa_sum;
   logic               w_fa_cout;
   logic [WIDTH-1:0]   w_acc_next;

   m_FA u_fa (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .o_s    (w_fa_sum),
      .o_cout (w_fa_cout)
   );

   // New sum bit enters at the MSB; after WIDTH shifts the first (LSB) sum
   // bit has reached bit 0. Written as a shift of the concatenation so the
   // same expression also covers WIDTH=1.
   assign w_acc_next = WIDTH'({w_fa_sum, r_acc} >> 1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         // NOTE: the datapath registers are reset as well, so an aborted
         // operation leaves no stale result and w_s/w_cout read 0.
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_s         <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // r_in_ready is 1 throughout IDLE, so w_in_valid alone
               // completes the handshake here.
               if (w_in_valid) begin
                  r_a        <= w_a;
                  r_b        <= w_op ? ~w_b : w_b;
                  r_carry    <= w_op | w_cin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end

            RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_fa_cout;
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + ONE;
               if (r_cnt == LAST) begin
                  r_s         <= w_acc_next;
                  r_cout      <= w_fa_cout;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end

            DONE: begin
               // Return to IDLE only; the next accept needs a fresh IDLE cycle.
               if (w_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign w_in_ready  = r_in_ready;
   assign w_out_valid = r_out_valid;
   assign w_s         = r_s;
   assign w_cout      = r_cout;

endmodule : m_serial_add_ctrl

// File: tb/tb_m_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_m_serial_add_ctrl
// Scoreboard bench for m_serial_add_ctrl (WIDTH=8). Accepted requests push
// an arithmetic reference result; a separate monitor pops and compares on
// each output handshake, and also checks latency and hold stability.
// ----------------------------------------------------------------------------
module tb_m_serial_add_ctrl;

   localparam int W  = 8;
   localparam int W1 = W + 1;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      int           acc_cyc;
   } exp_t;

   logic         w_clk = 1'b0;
   logic         w_rst;
   logic         w_in_valid;
   logic         w_in_ready;
   logic [W-1:0] w_a;
   logic [W-1:0] w_b;
   logic         w_cin;
   logic         w_op;
   logic         w_out_valid;
   logic         w_out_ready;
   logic [W-1:0] w_s;
   logic         w_cout;

   exp_t   q[$];
   exp_t   mon_e;
   int     checks   = 0;
   int     failures = 0;
   int     cyc      = 0;
   int     n_acc    = 0;
   int     n_done   = 0;
   int     last_acc = -1;
   bit     b2b_mode = 1'b0;
   bit     rand_ready_mode = 1'b0;
   logic         prev_valid = 1'b0;
   logic [W-1:0] prev_s;
   logic         prev_cout;

   always #5 w_clk = ~w_clk;

   m_serial_add_ctrl #(.WIDTH(W)) dut (
      .w_clk       (w_clk),
      .w_rst       (w_rst),
      .w_in_valid  (w_in_valid),
      .w_in_ready  (w_in_ready),
      .w_a         (w_a),
      .w_b         (w_b),
      .w_cin       (w_cin),
      .w_op        (w_op),
      .w_out_valid (w_out_valid),
      .w_out_ready (w_out_ready),
      .w_s         (w_s),
      .w_cout      (w_cout)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic, subtract as A-B with no-borrow flag.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic op, input int c);
      exp_t        e;
      logic [W:0]  t;
      if (!op) begin
         t      = W1'(a) + W1'(b) + W1'(cin);
         e.s    = t[W-1:0];
         e.cout = t[W];
      end else begin
         e.s    = a - b;
         e.cout = (a >= b);
      end
      e.acc_cyc = c;
      return e;
   endfunction

   always @(posedge w_clk) cyc <= cyc + 1;

   // Stimulus side of the scoreboard: record every accepted request.
   always @(negedge w_clk) begin
      if (!w_rst && w_in_valid && w_in_ready) begin
         n_acc++;
         q.push_back(model(w_a, w_b, w_cin, w_op, cyc));
         if (b2b_mode && last_acc >= 0)
            check("b2b_period", 64'(cyc - last_acc), 64'(W + 2));
         last_acc = cyc;
      end
   end

   // Monitor: latency on the first valid cycle, stability while held,
   // result comparison on the handshake.
   always @(negedge w_clk) begin
      if (w_rst) begin
         prev_valid = 1'b0;
      end else if (w_out_valid) begin
         check("in_ready_in_done", 64'(w_in_ready), 64'(0));
         if (!prev_valid) begin
            check("result_expected", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0)
               check("latency", 64'(cyc - q[0].acc_cyc), 64'(W + 1));
         end else begin
            check("s_stable", 64'(w_s), 64'(prev_s));
            check("cout_stable", 64'(w_cout), 64'(prev_cout));
         end
         if (w_out_ready && q.size() != 0) begin
            mon_e = q.pop_front();
            n_done++;
            check("s", 64'(w_s), 64'(mon_e.s));
            check("cout", 64'(w_cout), 64'(mon_e.cout));
         end
         prev_valid = w_out_valid && !w_out_ready;
         prev_s     = w_s;
         prev_cout  = w_cout;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic tick();
      @(posedge w_clk);
      #1;
      if (rand_ready_mode) w_out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!w_in_ready && n < 200) begin
         tick();
         n++;
      end
      check("ready_timeout", 64'(w_in_ready), 64'(1));
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic op);
      wait_ready();
      w_a = a; w_b = b; w_cin = cin; w_op = op;
      w_in_valid = 1'b1;
      tick();
      w_in_valid = 1'b0;
      // Scramble operands: they must only be sampled at accept.
      w_a = W'($urandom); w_b = W'($urandom);
      w_cin = 1'($urandom); w_op = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || w_out_valid) && n < 500) begin
         tick();
         n++;
      end
      check("drain_timeout", 64'(q.size()), 64'(0));
   endtask

   task automatic send_and_check(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic op,
                                 input logic [W-1:0] s_req, input logic c_req);
      send(a, b, cin, op);
      drain();
      tick();
      check("retained_s", 64'(w_s), 64'(s_req));
      check("retained_cout", 64'(w_cout), 64'(c_req));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_before;
      int sent;
      int guard;
      logic was_ready;

      w_rst = 1'b1; w_in_valid = 1'b0; w_a = '0; w_b = '0;
      w_cin = 1'b0; w_op = 1'b0; w_out_ready = 1'b1;
      tick();
      tick();
      check("rst_out_valid", 64'(w_out_valid), 64'(0));
      check("rst_s", 64'(w_s), 64'(0));
      check("rst_cout", 64'(w_cout), 64'(0));
      w_rst = 1'b0;
      tick();
      check("rst_in_ready", 64'(w_in_ready), 64'(1));

      // Directed arithmetic cases.
      send_and_check(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
      send_and_check(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
      send_and_check(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
      send_and_check(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
      send_and_check(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);

      // Backpressure in DONE while in_valid/w_a toggle.
      w_out_ready = 1'b0;
      send(8'h33, 8'h44, 1'b0, 1'b0);
      guard = 0;
      while (!w_out_valid && guard < 50) begin
         tick();
         guard++;
      end
      check("bp_valid_timeout", 64'(w_out_valid), 64'(1));
      acc_before = n_acc;
      for (int i = 0; i < 5; i++) begin
         w_in_valid = ~w_in_valid;
         w_a = W'($urandom);
         tick();
      end
      check("bp_no_accept", 64'(n_acc), 64'(acc_before));
      w_in_valid = 1'b0;
      w_out_ready = 1'b1;
      tick();
      check("bp_idle_ready", 64'(w_in_ready), 64'(1));
      check("bp_idle_valid", 64'(w_out_valid), 64'(0));
      check("bp_retained_s", 64'(w_s), 64'(8'h77));

      // Reset in RUN cycle 4 aborts the operation.
      send(8'hA7, 8'h5C, 1'b0, 1'b0);
      tick(); tick(); tick();
      w_rst = 1'b1;
      q.delete();
      tick();
      w_rst = 1'b0;
      check("abort_out_valid", 64'(w_out_valid), 64'(0));
      check("abort_s", 64'(w_s), 64'(0));
      check("abort_in_ready", 64'(w_in_ready), 64'(1));
      for (int i = 0; i < W + 3; i++) tick();
      check("abort_no_result", 64'(w_out_valid), 64'(0));
      send_and_check(8'hC3, 8'h3D, 1'b1, 1'b0, 8'h01, 1'b1);

      // Back-to-back with in_valid held high.
      b2b_mode = 1'b1;
      last_acc = -1;
      w_a = W'($urandom); w_b = W'($urandom);
      w_cin = 1'($urandom); w_op = 1'($urandom);
      w_in_valid = 1'b1;
      sent = 0;
      guard = 0;
      while (sent < 20 && guard < 20 * (W + 2) + 50) begin
         was_ready = w_in_ready;
         tick();
         guard++;
         if (was_ready) begin
            sent++;
            w_a = W'($urandom); w_b = W'($urandom);
            w_cin = 1'($urandom); w_op = 1'($urandom);
         end
      end
      w_in_valid = 1'b0;
      check("b2b_count", 64'(sent), 64'(20));
      drain();
      b2b_mode = 1'b0;

      // Random operands, gaps and consumer backpressure.
      rand_ready_mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      rand_ready_mode = 1'b0;
      w_out_ready = 1'b1;
      drain();

      // One request was aborted by reset and never completes.
      check("completed_count", 64'(n_done), 64'(n_acc - 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_m_serial_add_ctrl
